// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared state encodings, wait guard and master indices
package dmem_port_arbiter_pkg;
  typedef enum logic [2:0] {
    DRAIN = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int   WAIT_GUARD = 4;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// rr_pick2: two-input round-robin / fixed-priority pick
module rr_pick2
  import dmem_port_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic fixed_i,
  output logic grant_o,
  output logic valid_o
);
  assign valid_o = req0_i | req1_i;
  assign grant_o = (req0_i & req1_i) ? (fixed_i ? M0 : ~last_i) : (req1_i ? M1 : M0);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data memory between two masters, sequencing
// strobe, stall window and read-data capture into a one-cycle ack.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sign_mask,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sign_mask,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        busy
);
  state_t      state_q, state_d;
  logic        gnt_q, gnt_d, last_q, last_d, seen_q, seen_d, we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [3:0]  mask_q, mask_d;
  logic        rd_q, rd_d, wr_q, wr_d, ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
  logic        pick, pick_valid, finish;

  rr_pick2 u_pick (
    .req0_i (m0_req),
    .req1_i (m1_req),
    .last_i (last_q),
    .fixed_i(FIXED_PRIO != 0),
    .grant_o(pick),
    .valid_o(pick_valid)
  );

  // Complete after a seen stall window ends, or when the guard expires without any stall.
  assign finish = !mem_clk_stall && (seen_q || cnt_q == 2'(WAIT_GUARD - 1));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    seen_d   = seen_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state_q)
      DRAIN: state_d = mem_clk_stall ? DRAIN : IDLE;
      IDLE: if (pick_valid) begin
        state_d = ISSUE;
        gnt_d   = pick;
        last_d  = pick;
        we_d    = pick ? m1_we : m0_we;
        addr_d  = pick ? m1_addr : m0_addr;
        wdata_d = pick ? m1_wdata : m0_wdata;
        mask_d  = pick ? m1_sign_mask : m0_sign_mask;
        wr_d    = we_d;
        rd_d    = !we_d;
      end
      ISSUE: begin
        state_d = WAIT;
        seen_d  = 1'b0;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d  = cnt_q + 2'd1;
        seen_d = seen_q | mem_clk_stall;
        if (finish) begin
          state_d  = DONE;
          ack0_d   = gnt_q == M0;
          ack1_d   = gnt_q == M1;
          rdata0_d = (seen_q && !we_q && gnt_q == M0) ? mem_read_data : rdata0_q;
          rdata1_d = (seen_q && !we_q && gnt_q == M1) ? mem_read_data : rdata1_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = DRAIN;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DRAIN;
      gnt_q    <= M0;
      last_q   <= M1;
      seen_q   <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      seen_q   <= seen_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign m0_ack         = ack0_q;
  assign m1_ack         = ack1_q;
  assign m0_rdata       = rdata0_q;
  assign m1_rdata       = rdata1_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = rd_q;
  assign mem_memwrite   = wr_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the round-robin and fixed-priority arbiters
module tb_dmem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_sign_mask = 0, m1_sign_mask = 0;
  logic [31:0] mem_read_data = 0, mdl_data = 0;
  logic        mdl_stall = 0, tb_stall = 0, stall_en = 1;
  logic [1:0]  mdl_cnt = 0;
  logic        mem_clk_stall;
  logic        r_m0_ack, r_m1_ack, r_rd, r_wr, r_busy;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_addr, r_wdata;
  logic [3:0]  r_mask;
  logic        f_m0_ack, f_m1_ack, f_rd, f_wr, f_busy;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_addr, f_wdata;
  logic [3:0]  f_mask;
  int          n_chk = 0, n_pass = 0;
  int          n_rr, n_fp;
  int          rr_seq[4], rr_cyc[4], fp_seq[4];

  assign mem_clk_stall = mdl_stall | tb_stall;
  always #5 clk = ~clk;

  dmem_port_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sign_mask(m0_sign_mask), .m0_ack(r_m0_ack), .m0_rdata(r_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sign_mask(m1_sign_mask), .m1_ack(r_m1_ack), .m1_rdata(r_m1_rdata),
    .mem_addr(r_addr), .mem_write_data(r_wdata), .mem_sign_mask(r_mask),
    .mem_memread(r_rd), .mem_memwrite(r_wr), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall), .busy(r_busy)
  );

  dmem_port_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sign_mask(m0_sign_mask), .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sign_mask(m1_sign_mask), .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
    .mem_addr(f_addr), .mem_write_data(f_wdata), .mem_sign_mask(f_mask),
    .mem_memread(f_rd), .mem_memwrite(f_wr), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall), .busy(f_busy)
  );

  // Memory model: two stall cycles after each strobe, no reset of its own.
  always @(posedge clk) begin
    if ((r_rd | r_wr) && stall_en) begin
      mdl_stall <= 1'b1;
      mdl_cnt   <= 2'd2;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 2'd1;
      if (mdl_cnt == 2'd1) mdl_stall <= 1'b0;
    end
    if (r_rd) mem_read_data <= mdl_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", r_busy, 1);
    chk("rst_ack", {r_m0_ack, r_m1_ack}, 0);
    chk("rst_strobe", {r_rd, r_wr}, 0);
    chk("rst_addr", r_addr, 0);
    chk("rst_wdata", r_wdata, 0);
    chk("rst_mask", r_mask, 0);
    chk("rst_rdata", r_m0_rdata | r_m1_rdata, 0);
    reset = 0;
    tick();
    chk("drain_to_idle", r_busy, 0);

    mdl_data = 32'hDEADBEEF;
    m0_addr = 32'h1004; m0_we = 0; m0_sign_mask = 4'b0010; m0_req = 1;
    tick();
    chk("t1_rd_strobe", r_rd, 1);
    chk("t1_wr_strobe", r_wr, 0);
    chk("t1_addr", r_addr, 32'h1004);
    chk("t1_mask", r_mask, 4'b0010);
    tick();
    chk("t1_rd_pulse", r_rd, 0);
    tick(); tick();
    chk("t1_no_early_ack", r_m0_ack, 0);
    tick();
    chk("t1_m0_ack", r_m0_ack, 1);
    chk("t1_m0_rdata", r_m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_ack", r_m1_ack, 0);
    m0_req = 0;
    tick();
    chk("t1_ack_pulse", r_m0_ack, 0);
    chk("t1_idle", r_busy, 0);

    m1_addr = 32'h2000; m1_wdata = 32'hA5; m1_sign_mask = 4'b0100; m1_we = 1; m1_req = 1;
    tick();
    chk("t2_wr_strobe", r_wr, 1);
    chk("t2_rd_strobe", r_rd, 0);
    chk("t2_addr", r_addr, 32'h2000);
    chk("t2_wdata", r_wdata, 32'hA5);
    chk("t2_mask", r_mask, 4'b0100);
    tick();
    chk("t2_wr_pulse", r_wr, 0);
    tick(); tick(); tick();
    chk("t2_m1_ack", r_m1_ack, 1);
    chk("t2_m0_ack", r_m0_ack, 0);
    chk("t2_m1_rdata", r_m1_rdata, 0);
    m1_req = 0;
    tick();

    m0_we = 0; m1_we = 0; m0_req = 1; m1_req = 1;
    n_rr = 0; n_fp = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk("rr_one_ack", r_m0_ack & r_m1_ack, 0);
      if (r_m0_ack | r_m1_ack) begin
        if (n_rr < 4) begin rr_seq[n_rr] = int'(r_m1_ack); rr_cyc[n_rr] = i; end
        n_rr++;
      end
      if (f_m0_ack | f_m1_ack) begin
        if (n_fp < 4) fp_seq[n_fp] = int'(f_m1_ack);
        n_fp++;
      end
      if (n_rr >= 4) begin m0_req = 0; m1_req = 0; end
    end
    chk("rr_count", n_rr, 4);
    chk("fp_count", n_fp, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", rr_seq[k], k % 2);
      chk("rr_spacing", rr_cyc[k], 5 + 6 * k);
      chk("fp_order", fp_seq[k], 0);
    end

    mdl_data = 32'h12345678;
    m0_addr = 32'h1004; m0_req = 1;
    tick(); tick();
    reset = 1; tb_stall = 1; m0_req = 0;
    tick();
    chk("t4_rst_busy", r_busy, 1);
    chk("t4_rst_ack", {r_m0_ack, r_m1_ack}, 0);
    chk("t4_rst_strobe", {r_rd, r_wr}, 0);
    chk("t4_rst_addr", r_addr, 0);
    chk("t4_rst_rdata", r_m0_rdata, 0);
    reset = 0; m0_addr = 32'h30; m0_req = 1;
    tick();
    chk("t4_drain_strobe", r_rd, 0);
    chk("t4_drain_busy", r_busy, 1);
    tick();
    chk("t4_drain_strobe2", r_rd, 0);
    tb_stall = 0;
    tick();
    chk("t4_idle_strobe", r_rd, 0);
    tick();
    chk("t4_issue", r_rd, 1);
    chk("t4_addr", r_addr, 32'h30);
    tick(); tick(); tick(); tick();
    chk("t4_ack", r_m0_ack, 1);
    chk("t4_rdata", r_m0_rdata, 32'h12345678);
    m0_req = 0;
    tick();

    stall_en = 0; mdl_data = 32'hCAFEF00D;
    m1_addr = 32'h44; m1_we = 0; m1_req = 1;
    tick();
    chk("t5_issue", r_rd, 1);
    tick(); tick(); tick(); tick();
    chk("t5_no_ack_yet", r_m1_ack, 0);
    tick();
    chk("t5_guard_ack", r_m1_ack, 1);
    chk("t5_rdata_kept", r_m1_rdata, 0);
    m1_req = 0;
    tick();
    chk("t5_idle", r_busy, 0);
    chk("t5_ack_pulse", r_m1_ack, 0);

    stall_en = 1; mdl_data = 32'h0BADF00D;
    m0_addr = 32'h40; m0_we = 0; m0_req = 1;
    tick();
    m0_addr = 32'h80; m0_we = 1; m0_wdata = 32'h99;
    chk("t6_rd", r_rd, 1);
    chk("t6_wr", r_wr, 0);
    chk("t6_addr", r_addr, 32'h40);
    tick(); tick();
    chk("t6_addr_wait", r_addr, 32'h40);
    chk("t6_no_wr", r_wr, 0);
    tick(); tick();
    chk("t6_ack", r_m0_ack, 1);
    chk("t6_rdata", r_m0_rdata, 32'h0BADF00D);
    m0_req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
